// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-ported memory between the CPU and the GPU frame loader.
// The GPU wins ties, but a run-length limit guarantees the CPU a grant under continuous GPU traffic.
module mem_port_arbiter_chk (
  input logic clk,
  input logic clr,
  input logic cpu_req,
  input logic gpu_req,
  input logic cpu_gnt,
  input logic gpu_gnt,
  input logic cpu_rvalid,
  input logic gpu_rvalid
);
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!clr) !(cpu_gnt && gpu_gnt));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (!clr) !(cpu_rvalid && gpu_rvalid));
  a_cpu_gnt_req: assert property (@(posedge clk) disable iff (!clr) cpu_gnt |-> cpu_req);
  a_gpu_gnt_req: assert property (@(posedge clk) disable iff (!clr) gpu_gnt |-> gpu_req);
  a_no_idle: assert property (@(posedge clk) disable iff (!clr) (cpu_req || gpu_req) |-> (cpu_gnt || gpu_gnt));
endmodule

module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_GPU_RUN = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_we,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  gpu_req,
  input  logic [ADDR_WIDTH-1:0] gpu_addr,
  input  logic [DATA_WIDTH-1:0] gpu_wdata,
  input  logic                  gpu_we,
  output logic                  gpu_gnt,
  output logic                  gpu_rvalid,
  output logic [DATA_WIDTH-1:0] gpu_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            owner
);
  localparam int RUN_W = $clog2(MAX_GPU_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_GPU_RUN);
  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_CPU  = 2'b01;
  localparam logic [1:0] TAG_GPU  = 2'b10;

  logic [RUN_W-1:0] gpu_run_r;
  logic [RUN_W-1:0] gpu_run_next_s;
  logic [1:0]       rd_tag_r;
  logic [1:0]       rd_tag_next_s;
  logic [1:0]       owner_r;
  logic [1:0]       owner_next_s;
  logic             cpu_win_s;
  logic             gpu_win_s;

  function automatic logic [1:0] grant_code(input logic cpu_hit, input logic gpu_hit);
    case ({cpu_hit, gpu_hit})
      2'b10:   grant_code = TAG_CPU;
      2'b01:   grant_code = TAG_GPU;
      default: grant_code = TAG_NONE;
    endcase
  endfunction

  // Grant decision: GPU first unless the waiting CPU has seen a full GPU run.
  always_comb begin
    cpu_win_s = 1'b0;
    gpu_win_s = 1'b0;
    if (!clr) begin
      cpu_win_s = 1'b0;
      gpu_win_s = 1'b0;
    end else if (gpu_req && (!cpu_req || (gpu_run_r < RUN_MAX))) begin
      gpu_win_s = 1'b1;
    end else if (cpu_req) begin
      cpu_win_s = 1'b1;
    end else begin
      cpu_win_s = 1'b0;
      gpu_win_s = 1'b0;
    end
  end

  // Memory port mux; an idle port parks on the CPU address with writes disabled.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (gpu_win_s) begin
      mem_addr  = gpu_addr;
      mem_wdata = gpu_wdata;
      mem_we    = gpu_we;
    end else if (cpu_win_s) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else begin
      mem_we    = 1'b0;
    end
  end

  // Next-state for the GPU run counter, read tag and owner.
  always_comb begin
    gpu_run_next_s = gpu_run_r;
    if (!cpu_req || cpu_win_s) begin
      gpu_run_next_s = {RUN_W{1'b0}};
    end else if (gpu_win_s && (gpu_run_r < RUN_MAX)) begin
      gpu_run_next_s = gpu_run_r + RUN_W'(1);
    end else begin
      gpu_run_next_s = gpu_run_r;
    end
    rd_tag_next_s = grant_code(cpu_win_s & ~cpu_we, gpu_win_s & ~gpu_we);
    owner_next_s  = grant_code(cpu_win_s, gpu_win_s);
  end

  // State registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      gpu_run_r <= {RUN_W{1'b0}};
      rd_tag_r  <= TAG_NONE;
      owner_r   <= TAG_NONE;
    end else begin
      gpu_run_r <= gpu_run_next_s;
      rd_tag_r  <= rd_tag_next_s;
      owner_r   <= owner_next_s;
    end
  end

  assign cpu_gnt    = cpu_win_s;
  assign gpu_gnt    = gpu_win_s;
  assign cpu_rvalid = clr & (rd_tag_r == TAG_CPU);
  assign gpu_rvalid = clr & (rd_tag_r == TAG_GPU);
  assign cpu_rdata  = mem_rdata;
  assign gpu_rdata  = mem_rdata;
  assign owner      = owner_r;

  mem_port_arbiter_chk u_chk (
    .clk        (clk),
    .clr        (clr),
    .cpu_req    (cpu_req),
    .gpu_req    (gpu_req),
    .cpu_gnt    (cpu_gnt),
    .gpu_gnt    (gpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .gpu_rvalid (gpu_rvalid)
  );
endmodule
